// File: rtl/spi_slave_shift.sv
// spi_slave_shift: SPI target shift engine running entirely in the sys_clock domain.
// The block oversamples sclk, cs_n and mosi. It deserialises mosi into words and
// serialises a single-entry buffered transmit word onto miso.
//
// Ports:
//   sys_clock, reset_n   system clock (rising edge) and async active-low reset
//   clock_mode[1:0]      {CPOL, CPHA}, latched when synchronised cs_n falls
//   sclk, cs_n, mosi     asynchronous SPI inputs
//   miso                 serial data out (0 while idle)
//   tx_data/tx_valid     parallel transmit word in; tx_ready = buffer empty
//   tx_underrun          1-cycle pulse: a load found the buffer empty
//   rx_data/rx_valid     last received word, rx_valid pulses once per word
//   busy                 synchronised cs_n is low
//
// Build option: define SPI_SLAVE_LSB_FIRST_EN to shift LSB first on both rx and tx.
// By default both directions shift MSB first.
module spi_slave_shift #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  sys_clock,
  input  logic                  reset_n,
  input  logic [1:0]            clock_mode,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_underrun,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic                   lead_edge, trail_edge, sample_edge, shift_edge;

  logic [1:0]             mode_q;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   done_q;
  logic [DATA_WIDTH-1:0]  rx_shift, rx_next;
  logic [DATA_WIDTH-1:0]  tx_shift, tx_shifted, tx_buf;
  logic                   buf_full, tx_out;
  logic                   load, do_sample, do_shift, abort, wr;

  // Input synchronisers plus one extra registered copy for edge detection.
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign cs_rise   = cs_s & ~cs_d;

  assign lead_edge   = mode_q[1] ? sclk_fall : sclk_rise;
  assign trail_edge  = mode_q[1] ? sclk_rise : sclk_fall;
  assign sample_edge = mode_q[0] ? trail_edge : lead_edge;
  assign shift_edge  = mode_q[0] ? lead_edge : trail_edge;

`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign rx_next    = {mosi_s, rx_shift[DATA_WIDTH-1:1]};
  assign tx_shifted = {1'b0, tx_shift[DATA_WIDTH-1:1]};
  assign tx_out     = tx_shift[0];
`else
  assign rx_next    = {rx_shift[DATA_WIDTH-2:0], mosi_s};
  assign tx_shifted = {tx_shift[DATA_WIDTH-2:0], 1'b0};
  assign tx_out     = tx_shift[DATA_WIDTH-1];
`endif

  assign wr       = tx_valid & ~buf_full;
  assign tx_ready = ~buf_full;
  assign busy     = ~cs_s;
  assign miso     = (state_q == ACTIVE) ? tx_out : 1'b0;

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    do_sample = 1'b0;
    do_shift  = 1'b0;
    abort     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = ACTIVE;
          // CPHA=0 must present the first bit before the first sclk edge.
          load    = ~clock_mode[0];
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d = IDLE;
          abort   = 1'b1;
        end else begin
          do_sample = sample_edge;
          if (shift_edge) begin
            // CPHA=0 reloads on the trailing edge right after the last sample.
            // CPHA=1 reloads on the leading edge of each new word.
            if (mode_q[0] ? (bit_cnt == '0) : done_q) load = 1'b1;
            else                                       do_shift = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_q      <= '0;
      bit_cnt     <= '0;
      done_q      <= 1'b0;
      rx_shift    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_shift    <= '0;
      tx_buf      <= '0;
      buf_full    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;

      if (state_q == IDLE && cs_fall) begin
        mode_q  <= clock_mode;
        bit_cnt <= '0;
        done_q  <= 1'b0;
      end

      if (abort) begin
        bit_cnt <= '0;
        done_q  <= 1'b0;
      end

      if (do_sample) begin
        rx_shift <= rx_next;
        if (bit_cnt == LAST_BIT) begin
          bit_cnt  <= '0;
          rx_data  <= rx_next;
          rx_valid <= 1'b1;
          done_q   <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end

      if (load || do_shift) done_q <= 1'b0;

      // An empty buffer with a write in the same cycle bypasses the write straight into the shifter.
      if (load) begin
        if (buf_full) begin
          tx_shift <= tx_buf;
          buf_full <= 1'b0;
        end else if (tx_valid) begin
          tx_shift <= tx_data;
        end else begin
          tx_shift    <= '0;
          tx_underrun <= 1'b1;
        end
      end else if (do_shift) begin
        tx_shift <= tx_shifted;
      end

      if (wr && !load) begin
        tx_buf   <= tx_data;
        buf_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_shift.sv
// tb_spi_slave_shift: directed test of spi_slave_shift, with the bench acting as the SPI master.
// The bench drives the SPI pins and checks rx words, miso bits and the handshake pulses
// against expected values worked out by hand.
module tb_spi_slave_shift;

  localparam int unsigned HP = 4;

  logic       sys_clock = 1'b0;
  logic       reset_n;
  logic [1:0] clock_mode;
  logic       sclk, cs_n, mosi, miso;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, tx_underrun;
  logic [7:0] rx_data;
  logic       rx_valid, busy;

  int unsigned assertions = 0;
  int unsigned failures   = 0;
  int unsigned rx_cnt     = 0;
  int unsigned ur_cnt     = 0;
  logic [7:0]  rx_log [0:63];

  always #5 sys_clock = ~sys_clock;

  spi_slave_shift #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .sys_clock  (sys_clock),
    .reset_n    (reset_n),
    .clock_mode (clock_mode),
    .sclk       (sclk),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .miso       (miso),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_underrun(tx_underrun),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .busy       (busy)
  );

  // Pulse monitor: each high cycle of a 1-cycle strobe is seen at exactly one falling edge.
  always @(negedge sys_clock) begin
    if (rx_valid) begin
      rx_log[rx_cnt % 64] = rx_data;
      rx_cnt++;
    end
    if (tx_underrun) ur_cnt++;
  end

  task automatic push_tx(input logic [7:0] d);
    @(negedge sys_clock);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge sys_clock);
    tx_valid = 1'b0;
  endtask

  // SPI master: shifts out the low nbits of mo MSB first and collects miso on each sample edge.
  task automatic spi_xfer(input logic [1:0] mode, input int nbits, input logic [31:0] mo,
                          input bit release_cs, output logic [31:0] mi);
    logic cpol, cpha;
    cpol = mode[1];
    cpha = mode[0];
    mi   = '0;
    @(negedge sys_clock);
    clock_mode = mode;
    sclk       = cpol;
    repeat (6) @(negedge sys_clock);
    if (!cpha) mosi = mo[nbits-1];
    cs_n = 1'b0;
    repeat (8) @(negedge sys_clock);
    for (int i = nbits - 1; i >= 0; i--) begin
      if (!cpha) begin
        mi   = {mi[30:0], miso};
        sclk = ~cpol;
        repeat (HP) @(negedge sys_clock);
        sclk = cpol;
        if (i > 0) mosi = mo[i-1];
        repeat (HP) @(negedge sys_clock);
      end else begin
        sclk = ~cpol;
        mosi = mo[i];
        repeat (HP) @(negedge sys_clock);
        mi   = {mi[30:0], miso};
        sclk = cpol;
        repeat (HP) @(negedge sys_clock);
      end
    end
    if (release_cs) begin
      cs_n = 1'b1;
      repeat (8) @(negedge sys_clock);
    end
  endtask

  task automatic test_reset;
    reset_n    = 1'b0;
    clock_mode = 2'b00;
    sclk       = 1'b0;
    cs_n       = 1'b1;
    mosi       = 1'b0;
    tx_data    = '0;
    tx_valid   = 1'b0;
    repeat (3) @(negedge sys_clock);
    assertions++; if (miso !== 1'b0) begin failures++; $display("FAIL reset_miso: got %b expected 0", miso); end
    assertions++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_tx_ready: got %b expected 1", tx_ready); end
    assertions++; if (tx_underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun: got %b expected 0", tx_underrun); end
    assertions++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    assertions++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    assertions++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    reset_n = 1'b1;
    repeat (4) @(negedge sys_clock);
  endtask

  task automatic test_mode0;
    logic [31:0] mi;
    int unsigned r0;
    push_tx(8'hA5);
    assertions++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL mode0_buf_full: got %b expected 0", tx_ready); end
    r0 = rx_cnt;
    spi_xfer(2'b00, 8, 32'h3C, 1'b1, mi);
    assertions++; if (rx_cnt - r0 != 1) begin failures++; $display("FAIL mode0_rx_pulses: got %0d expected 1", rx_cnt - r0); end
    assertions++; if (rx_data !== 8'h3C) begin failures++; $display("FAIL mode0_rx_data: got %h expected 3c", rx_data); end
    assertions++; if (mi[7:0] !== 8'hA5) begin failures++; $display("FAIL mode0_miso: got %h expected a5", mi[7:0]); end
    assertions++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL mode0_tx_ready: got %b expected 1", tx_ready); end
  endtask

  task automatic test_modes;
    logic [31:0] mi;
    logic [1:0]  md;
    int unsigned r0;
    for (int m = 1; m <= 3; m++) begin
      md = 2'(m);
      push_tx(8'h7E);
      r0 = rx_cnt;
      spi_xfer(md, 8, 32'h81, 1'b1, mi);
      assertions++; if (rx_cnt - r0 != 1) begin failures++; $display("FAIL mode%0d_rx_pulses: got %0d expected 1", m, rx_cnt - r0); end
      assertions++; if (rx_data !== 8'h81) begin failures++; $display("FAIL mode%0d_rx_data: got %h expected 81", m, rx_data); end
      assertions++; if (mi[7:0] !== 8'h7E) begin failures++; $display("FAIL mode%0d_miso: got %h expected 7e", m, mi[7:0]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] mi;
    int unsigned r0, u0;
    push_tx(8'hF0);
    r0 = rx_cnt;
    u0 = ur_cnt;
    fork
      spi_xfer(2'b01, 16, 32'h1122, 1'b1, mi);
      begin
        repeat (40) @(negedge sys_clock);
        push_tx(8'h0F);
      end
    join
    assertions++; if (rx_cnt - r0 != 2) begin failures++; $display("FAIL b2b_rx_pulses: got %0d expected 2", rx_cnt - r0); end
    assertions++; if (rx_log[r0 % 64] !== 8'h11) begin failures++; $display("FAIL b2b_word0: got %h expected 11", rx_log[r0 % 64]); end
    assertions++; if (rx_log[(r0 + 1) % 64] !== 8'h22) begin failures++; $display("FAIL b2b_word1: got %h expected 22", rx_log[(r0 + 1) % 64]); end
    assertions++; if (mi[15:0] !== 16'hF00F) begin failures++; $display("FAIL b2b_miso: got %h expected f00f", mi[15:0]); end
    assertions++; if (ur_cnt - u0 != 0) begin failures++; $display("FAIL b2b_underrun: got %0d expected 0", ur_cnt - u0); end
  endtask

  task automatic test_underrun;
    logic [31:0] mi;
    int unsigned u0;
    assertions++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL underrun_pre_empty: got %b expected 1", tx_ready); end
    u0 = ur_cnt;
    spi_xfer(2'b01, 8, 32'h5A, 1'b1, mi);
    assertions++; if (ur_cnt - u0 != 1) begin failures++; $display("FAIL underrun_pulses: got %0d expected 1", ur_cnt - u0); end
    assertions++; if (mi[7:0] !== 8'h00) begin failures++; $display("FAIL underrun_miso: got %h expected 00", mi[7:0]); end
    assertions++; if (rx_data !== 8'h5A) begin failures++; $display("FAIL underrun_rx_data: got %h expected 5a", rx_data); end
  endtask

  task automatic test_abort;
    logic [31:0] mi;
    int unsigned r0;
    r0 = rx_cnt;
    spi_xfer(2'b00, 5, 32'h1F, 1'b1, mi);
    assertions++; if (rx_cnt - r0 != 0) begin failures++; $display("FAIL abort_rx_pulses: got %0d expected 0", rx_cnt - r0); end
    assertions++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b expected 0", busy); end
    r0 = rx_cnt;
    spi_xfer(2'b00, 8, 32'h55, 1'b1, mi);
    assertions++; if (rx_cnt - r0 != 1) begin failures++; $display("FAIL abort_next_pulses: got %0d expected 1", rx_cnt - r0); end
    assertions++; if (rx_data !== 8'h55) begin failures++; $display("FAIL abort_next_rx_data: got %h expected 55", rx_data); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] mi;
    int unsigned r0;
    push_tx(8'hFF);
    spi_xfer(2'b00, 3, 32'h7, 1'b0, mi);
    push_tx(8'h12);
    assertions++; if (busy !== 1'b1) begin failures++; $display("FAIL midreset_pre_busy: got %b expected 1", busy); end
    assertions++; if (miso !== 1'b1) begin failures++; $display("FAIL midreset_pre_miso: got %b expected 1", miso); end
    @(negedge sys_clock);
    reset_n = 1'b0;
    #1;
    assertions++; if (miso !== 1'b0) begin failures++; $display("FAIL midreset_miso: got %b expected 0", miso); end
    assertions++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL midreset_tx_ready: got %b expected 1", tx_ready); end
    assertions++; if (tx_underrun !== 1'b0) begin failures++; $display("FAIL midreset_underrun: got %b expected 0", tx_underrun); end
    assertions++; if (rx_data !== 8'h00) begin failures++; $display("FAIL midreset_rx_data: got %h expected 00", rx_data); end
    assertions++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL midreset_rx_valid: got %b expected 0", rx_valid); end
    assertions++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    cs_n = 1'b1;
    sclk = 1'b0;
    repeat (4) @(negedge sys_clock);
    reset_n = 1'b1;
    repeat (4) @(negedge sys_clock);
    push_tx(8'h96);
    r0 = rx_cnt;
    spi_xfer(2'b00, 8, 32'hC3, 1'b1, mi);
    assertions++; if (rx_cnt - r0 != 1) begin failures++; $display("FAIL postreset_rx_pulses: got %0d expected 1", rx_cnt - r0); end
    assertions++; if (rx_data !== 8'hC3) begin failures++; $display("FAIL postreset_rx_data: got %h expected c3", rx_data); end
    assertions++; if (mi[7:0] !== 8'h96) begin failures++; $display("FAIL postreset_miso: got %h expected 96", mi[7:0]); end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_modes();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave_shift.md
Name: spi_slave_shift

Overview:
- SPI slave (target) shift engine: the receiving end of the bus driven by our SPI master.
- Oversamples the external sclk, cs_n and mosi in the sys_clock domain and deserialises mosi into words; serialises a buffered transmit word onto miso.
- Sits between the SPI pins and the local register/FIFO logic; the parallel side uses valid/ready handshakes.

Parameters:
- DATA_WIDTH, 8, bits per SPI word (≥2).
- SYNC_STAGES, 2, flip-flop stages on each of sclk, cs_n and mosi (≥2).

Ports:
- sys_clock  in  1  system clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clock_mode  in  2  SPI mode: bit1 = CPOL, bit0 = CPHA. Captured at cs_n assertion.
- sclk  in  1  serial clock from the master (asynchronous).
- cs_n  in  1  chip select, active-low (asynchronous).
- mosi  in  1  serial data in.
- miso  out  1  serial data out.
- tx_data  in  DATA_WIDTH  word to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  transmit buffer is empty.
- tx_underrun  out  1  1-cycle pulse: a word was loaded while the buffer was empty.
- rx_data  out  DATA_WIDTH  last complete received word.
- rx_valid  out  1  1-cycle pulse: rx_data is updated.
- busy  out  1  synchronised cs_n is low (transfer active).

Behaviour:
- Reset values: miso=0, tx_ready=1, tx_underrun=0, rx_data=0, rx_valid=0, busy=0. All synchronisers are set to idle (sclk sync=0, cs_n sync=1). State=IDLE. bit_cnt=0.
- Synchronisation: sclk, cs_n and mosi each pass through SYNC_STAGES flops. Edge detection compares the last sync stage with one extra registered copy. Edge events are single-cycle strobes.
- Edges: leading edge = rising if CPOL=0, falling if CPOL=1; trailing edge is the opposite. Sample edge = leading if CPHA=0, trailing if CPHA=1. Shift edge = the other one.
- Timing constraint: sclk half-period ≥ 4 sys_clock cycles (master divide-by-8 or slower). Faster sclk is unsupported; behaviour is then undefined.
- State IDLE:
  - busy=0, miso=0.
  - On synced cs_n falling: latch clock_mode into mode_q, bit_cnt=0, go to ACTIVE.
  - If CPHA=0: load tx shift register at this point (see load rule).
- State ACTIVE, sample edge:
  - rx_shift = {rx_shift[DATA_WIDTH-2:0], mosi_sync}; bit_cnt++.
  - When bit_cnt reaches DATA_WIDTH-1 on this edge: rx_data takes the full word and rx_valid pulses on the next cycle; bit_cnt wraps to 0.
- State ACTIVE, shift edge:
  - CPHA=0: if the word just completed, load; otherwise shift left.
  - CPHA=1: if bit_cnt==0, load; otherwise shift left.
  - miso always equals tx_shift MSB while ACTIVE.
- Load rule:
  - If the buffer is full: tx_shift=tx_buf, buffer becomes empty, tx_ready=1 next cycle.
  - If the buffer is empty: tx_shift=0 and tx_underrun pulses.
- Transmit buffer:
  - tx_valid & tx_ready writes tx_buf and sets it full (tx_ready=0).
  - tx_valid while full is ignored.
  - A write and a load in the same cycle: the load takes the old buffer contents when full. When empty, the write is bypassed directly into tx_shift, with no underrun and tx_ready staying 1.
- cs_n deasserts mid-word (synced rising): abort, discard partial rx, no rx_valid. Return to IDLE, bit_cnt=0, miso=0. tx_buf contents are retained.
- Back-to-back words under continuous cs_n: no idle gap is required, and rx_valid pulses once per word.
- Asynchronous reset mid-transfer: all state returns to reset values immediately.

Optional Feature:
- Macro SPI_SLAVE_LSB_FIRST_EN.
- Defined: rx shifts in from the MSB end (right shift) and tx emits the LSB first (right shift, miso = tx_shift[0]). Word completion and handshakes are unchanged.
- Undefined: MSB first, as described above.

Test Plan:
- Mode 0, half-period 4 cycles, tx_data=0xA5 preloaded, master sends 0x3C → rx_data=0x3C with one rx_valid pulse; miso bits 1,0,1,0,0,1,0,1; tx_ready returns to 1 after the load.
- Modes 1, 2, 3 each with mosi 0x81, tx 0x7E → rx 0x81 and miso 0x7E in every mode.
- Two back-to-back words 0x11 then 0x22, with tx 0xF0 loaded before and 0x0F loaded during word 1 → two rx_valid pulses (0x11, 0x22); miso 0xF0 then 0x0F; no underrun.
- No tx word loaded, cs_n asserted → tx_underrun pulses once; miso=0 for the whole word.
- cs_n released after 5 bits of 0xFF → no rx_valid, busy falls, next full word 0x55 is received correctly.
- reset_n asserted after 3 bits → all outputs at reset values immediately; a subsequent transfer of 0xC3 succeeds.
